// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sequencer sharing one byte SPI master; SPI_ARB_TIMEOUT_EN adds a frame watchdog
module spi_txn_arbiter #(
  parameter int N_REQ = 4,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic               m_start,
  output logic [7:0]         m_data,
  input  logic               m_cs,
  output logic [N_REQ-1:0]   ss_n
);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [2:0] {IDLE, ARB, LAUNCH, BUSY, DONE, GAP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, win;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [7:0] data_q, data_d, gap_q, gap_d;
  logic start_q, start_d, err_q, err_d, found, timeout;
  if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("spi_txn_arbiter: parameter out of range");
  end
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  assign timeout = wd_q == WW'(TIMEOUT_CYCLES);
  assign wd_d = (state_q != LAUNCH && state_q != BUSY) ? '0 : timeout ? wd_q : wd_q + 1'b1;
  always_ff @(posedge clk)
    wd_q <= rst ? '0 : wd_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    win = rr_q;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (!found && req[(int'(rr_q) + i) % N_REQ]) begin
        win = PW'((int'(rr_q) + i) % N_REQ);
        found = 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    gnt_d = gnt_q;
    data_d = data_q;
    gap_d = gap_q;
    start_d = start_q;
    done_d = '0;
    err_d = 1'b0;
    case (state_q)
      IDLE: state_d = |req ? ARB : IDLE;
      ARB: if (found) begin
        state_d = LAUNCH;
        gnt_d = N_REQ'(1) << win;
        data_d = req_data[8*win +: 8];
        rr_d = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        start_d = 1'b1;
      end else state_d = IDLE;
      LAUNCH: if (timeout || !m_cs) begin
        state_d = timeout ? DONE : BUSY;
        start_d = 1'b0;
        done_d = timeout ? gnt_q : '0;
        err_d = timeout;
      end
      BUSY: if (timeout || m_cs) begin
        state_d = DONE;
        done_d = gnt_q;
        err_d = timeout;
      end
      DONE: begin
        state_d = GAP;
        gnt_d = '0;
        gap_d = 8'(GAP_CYCLES);
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        state_d = gap_q == 8'd1 ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      data_q <= '0;
      gap_q <= '0;
      start_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      data_q <= data_d;
      gap_q <= gap_d;
      start_q <= start_d;
      err_q <= err_d;
    end
  assign ss_n = (state_q == BUSY && !m_cs) ? ~gnt_q : '1;
  assign gnt = gnt_q;
  assign done = done_q;
  assign err = err_q;
  assign m_start = start_q;
  assign m_data = data_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed and randomized frames checked against a round-robin reference model
module tb_spi_txn_arbiter;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam int GAP = 4;
  localparam int LONG = TO > 100 ? 80 : 4;
  logic clk = 1'b0, rst = 1'b1, m_cs = 1'b1;
  logic [3:0] req = '0, gnt, done, ss_n;
  logic [31:0] req_data;
  logic err, m_start;
  logic [7:0] m_data;
  logic [7:0] bytes [4];
  int errors = 0, checks = 0, exp_rr = 0;
  spi_txn_arbiter #(.N_REQ(4), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .err(err), .m_start(m_start), .m_data(m_data), .m_cs(m_cs), .ss_n(ss_n)
  );
  always #5 clk = ~clk;
  always_comb req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(exp_rr + k) % 4]) return (exp_rr + k) % 4;
    return 0;
  endfunction
  task automatic new_bytes();
    for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
  endtask
  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt === 4'h0 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic frame(input logic [3:0] r, input int lat, input int dly, input int len, input bit hold);
    int n, w;
    logic [3:0] oh;
    w = pick(r);
    oh = 4'(1 << w);
    exp_rr = (w + 1) % 4;
    req = r;
    wait_gnt(n);
    if (lat >= 0) chk("latency", n, lat);
    chk("gnt", gnt, oh);
    chk("m_data", m_data, bytes[w]);
    chk("start_on", m_start, 1);
    chk("ss_n_launch", ss_n, 4'hF);
    if (!hold) req[w] = 1'b0;
    repeat (dly) @(negedge clk);
    chk("start_hold", m_start, 1);
    m_cs = 1'b0;
    @(negedge clk);
    chk("start_off", m_start, 0);
    chk("ss_n_busy", ss_n, 4'(~oh));
    repeat (len) @(negedge clk);
    chk("ss_n_busy_end", ss_n, 4'(~oh));
    chk("gnt_busy", gnt, oh);
    m_cs = 1'b1;
    @(negedge clk);
    chk("done", done, oh);
    chk("err", err, 0);
    chk("ss_n_done", ss_n, 4'hF);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("gnt_clear", gnt, 0);
  endtask
  initial begin
    int n, w;
    logic [3:0] oh;
    new_bytes();
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_start", m_start, 0);
    chk("rst_data", m_data, 0);
    chk("rst_ss_n", ss_n, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) frame(4'hF, i == 0 ? 2 : GAP + 2, 1, 3, 1'b1);
    new_bytes();
    bytes[1] = 8'hA5;
    frame(4'b0010, GAP + 2, 3, LONG, 1'b0);
    frame(4'b0010, GAP + 2, 0, 2, 1'b0);
    frame(4'b0100, GAP + 2, 1, 2, 1'b0);
    frame(4'b1001, GAP + 2, 2, 1, 1'b1);
    frame(4'b1001, GAP + 2, 0, 1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      new_bytes();
      frame(4'($urandom_range(1, 15)), GAP + 2, $urandom_range(0, 3), $urandom_range(1, 6), 1'($urandom));
    end
    req = 4'b0000;
    repeat (GAP + 2) @(negedge clk);
    chk("idle_gnt", gnt, 0);
    req = 4'b0010;
    wait_gnt(n);
    chk("pre_rst_gnt", gnt, 4'b0010);
    m_cs = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_ss_n", ss_n, 4'b1101);
    req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_ss_n", ss_n, 4'hF);
    chk("mid_rst_start", m_start, 0);
    chk("mid_rst_done", done, 0);
    m_cs = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_done", done, 0);
    exp_rr = 0;
    frame(4'hF, 2, 1, 2, 1'b0);
    new_bytes();
    w = pick(4'b0100);
    oh = 4'(1 << w);
    exp_rr = (w + 1) % 4;
    req = 4'b0100;
    wait_gnt(n);
    chk("to_gnt", gnt, oh);
    req = 4'b0000;
`ifdef SPI_ARB_TIMEOUT_EN
    n = 0;
    while (done === 4'h0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", n, TO + 1);
    chk("to_done", done, oh);
    chk("to_err", err, 1);
    chk("to_start", m_start, 0);
    chk("to_ss_n", ss_n, 4'hF);
    @(negedge clk);
    chk("to_err_pulse", err, 0);
`else
    repeat (60) begin
      @(negedge clk);
      chk("launch_wait", {err, done, m_start, gnt}, {1'b0, 4'h0, 1'b1, oh});
    end
    m_cs = 1'b0;
    @(negedge clk);
    m_cs = 1'b1;
    @(negedge clk);
    chk("late_done", done, oh);
    chk("late_err", err, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
